// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module   : coin_acceptor
// Purpose  : Synchronizes and debounces raw nickel/dime/quarter sensors and
//            emits one value strobe per physical coin to the vending core.
// Revision : 1.0 - initial release
// ============================================================================
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NICKEL_VAL      = 5,
  parameter int DIME_VAL        = 10,
  parameter int QUARTER_VAL     = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       coin_n,
  input  logic       coin_d,
  input  logic       coin_q,
  output logic       c,
  output logic [7:0] a,
  output logic       reject,
  output logic       busy,
  output logic [7:0] coin_count
);

  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    EMIT         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t             r_state;
  logic [2:0]         r_sync1;
  logic [2:0]         r_sync2;
  logic [2:0]         r_code;
  logic [c_CNT_W-1:0] r_cnt;

  logic [2:0] w_s;
  logic       w_one_hot;
  logic       w_multi;
  logic       w_latched_hi;
  logic       w_other_hi;
  logic [7:0] w_code_val;

  // Bit order {q, d, n} is used for both the synchronizer and the latched code
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= {coin_q, coin_d, coin_n};
      r_sync2 <= r_sync1;
    end
  end

  assign w_s          = r_sync2;
  assign w_one_hot    = (w_s == 3'b001) || (w_s == 3'b010) || (w_s == 3'b100);
  assign w_multi      = (w_s != 3'b000) && !w_one_hot;
  assign w_latched_hi = |(w_s & r_code);
  assign w_other_hi   = |(w_s & ~r_code);

  always_comb begin
    w_code_val = 8'd0;
    case (r_code)
      3'b001:  w_code_val = 8'(NICKEL_VAL);
      3'b010:  w_code_val = 8'(DIME_VAL);
      3'b100:  w_code_val = 8'(QUARTER_VAL);
      default: w_code_val = 8'd0;
    endcase
  end

  // Outputs are assigned alongside the state transition so they track the
  // registered state with no input-to-output combinational path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_code     <= 3'b000;
      r_cnt      <= '0;
      c          <= 1'b0;
      a          <= 8'd0;
      reject     <= 1'b0;
      busy       <= 1'b0;
      coin_count <= 8'd0;
    end else begin
      c      <= 1'b0;
      reject <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en && w_one_hot) begin
            r_code  <= w_s;
            r_cnt   <= c_CNT_W'(1);
            r_state <= DEBOUNCE;
            busy    <= 1'b1;
          end else if (en && w_multi) begin
            reject  <= 1'b1;
            r_state <= WAIT_RELEASE;
            busy    <= 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!w_latched_hi) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else if (w_other_hi) begin
            reject  <= 1'b1;
            r_state <= WAIT_RELEASE;
          end else if (r_cnt == c_CNT_W'(DEBOUNCE_CYCLES)) begin
            a       <= w_code_val;
            c       <= 1'b1;
            r_state <= EMIT;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        EMIT: begin
          if (coin_count != 8'hFF) begin
            coin_count <= coin_count + 8'd1;
          end
          r_state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (w_s == 3'b000) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_acceptor
// Purpose  : Scoreboard bench for coin_acceptor: directed scenarios plus
//            random coin episodes predicted by an episode-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_acceptor;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       coin_n;
  logic       coin_d;
  logic       coin_q;
  logic       c;
  logic [7:0] a;
  logic       reject;
  logic       busy;
  logic [7:0] coin_count;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(D),
    .NICKEL_VAL     (5),
    .DIME_VAL       (10),
    .QUARTER_VAL    (25)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .coin_n    (coin_n),
    .coin_d    (coin_d),
    .coin_q    (coin_q),
    .c         (c),
    .a         (a),
    .reject    (reject),
    .busy      (busy),
    .coin_count(coin_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_rej;
    logic [7:0] val;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_c_cyc = 0;
  int   busy_seen = 0;
  int   m_count = 0;
  int   m_a = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every strobe or reject the DUT presents must match the queue head
  always @(negedge clk) begin
    if (rst) begin
      if (busy) busy_seen++;
      if (c && reject) check("c_reject_overlap", 1, 0);
      if (c || reject) begin
        if (sbq.size() == 0) begin
          check(c ? "unexpected_c" : "unexpected_reject", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          check("event_kind_reject", int'(reject), int'(mon_e.is_rej));
          if (c) check("coin_value", int'(a), int'(mon_e.val));
        end
        if (c) last_c_cyc = cyc;
      end
    end
  end

  function automatic int coin_value(input logic [2:0] lines);
    case (lines)
      3'b001:  return 5;
      3'b010:  return 10;
      3'b100:  return 25;
      default: return 0;
    endcase
  endfunction

  // Episode outcome: lines raised together for n samples, then a quiet gap
  task automatic predict(input logic en_v, input logic [2:0] lines, input int n);
    exp_t e;
    if (en_v && lines != 3'b000) begin
      if ($countones(lines) >= 2) begin
        e.is_rej = 1'b1;
        e.val    = 8'd0;
        sbq.push_back(e);
      end else if (n >= D + 1) begin
        e.is_rej = 1'b0;
        e.val    = 8'(coin_value(lines));
        sbq.push_back(e);
        if (m_count < 255) m_count++;
        m_a = coin_value(lines);
      end
    end
  endtask

  task automatic end_check(input string tag);
    @(negedge clk);
    check({tag, "_events_pending"}, sbq.size(), 0);
    sbq.delete();
    check({tag, "_coin_count"}, int'(coin_count), m_count);
    check({tag, "_a"}, int'(a), m_a);
    check({tag, "_busy_idle"}, int'(busy), 0);
  endtask

  task automatic episode(input logic en_v, input logic [2:0] lines, input int n,
                         input int gap, input bit do_check, input string tag);
    predict(en_v, lines, n);
    @(posedge clk);
    #1;
    en = en_v;
    {coin_q, coin_d, coin_n} = lines;
    repeat (n) @(posedge clk);
    #1;
    {coin_q, coin_d, coin_n} = 3'b000;
    repeat (gap) @(posedge clk);
    if (do_check) end_check(tag);
  endtask

  initial begin
    int   s;
    logic [2:0] l;
    exp_t e;

    rst = 1'b0;
    en = 1'b1;
    {coin_q, coin_d, coin_n} = 3'b000;
    #2;
    check("reset_c", int'(c), 0);
    check("reset_a", int'(a), 0);
    check("reset_reject", int'(reject), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(coin_count), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Quarter held 10 cycles: latency and busy-release timing
    e.is_rej = 1'b0;
    e.val = 8'd25;
    sbq.push_back(e);
    m_count = 1;
    m_a = 25;
    @(posedge clk);
    #1 coin_q = 1'b1;
    s = cyc;
    repeat (10) @(posedge clk);
    #1 coin_q = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("busy_before_release", int'(busy), 1);
    @(posedge clk);
    @(negedge clk);
    check("busy_after_release", int'(busy), 0);
    check("c_latency", last_c_cyc - s, D + 3);
    repeat (4) @(posedge clk);
    end_check("quarter10");

    episode(1'b1, 3'b001, 3, 8, 1'b1, "nickel_glitch");
    episode(1'b1, 3'b001, D, 8, 1'b1, "nickel_boundary");
    episode(1'b1, 3'b010, 6, 8, 1'b1, "dime6");
    episode(1'b1, 3'b011, 8, 8, 1'b1, "n_d_reject");
    episode(1'b1, 3'b100, 50, 8, 1'b1, "quarter_hold");
    for (int i = 0; i < 4; i++) episode(1'b1, 3'b100, 5, 15, 1'b0, "");
    end_check("quarter_train");

    // Reset asserted two cycles into DEBOUNCE while a dime is held
    @(posedge clk);
    #1 coin_d = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_c", int'(c), 0);
    check("midreset_a", int'(a), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_count", int'(coin_count), 0);
    m_count = 0;
    m_a = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    e.is_rej = 1'b0;
    e.val = 8'd10;
    sbq.push_back(e);
    m_count = 1;
    m_a = 10;
    repeat (8) @(posedge clk);
    #1 coin_d = 1'b0;
    repeat (8) @(posedge clk);
    end_check("dime_after_reset");

    busy_seen = 0;
    episode(1'b0, 3'b100, 10, 8, 1'b1, "en_off");
    check("en_off_busy_seen", busy_seen, 0);

    for (int i = 0; i < 150; i++) begin
      l = 3'($urandom_range(1, 7));
      episode(($urandom_range(0, 3) != 0), l, int'($urandom_range(1, 12)), 8,
              1'b1, "random");
    end

    for (int i = 0; i < 260; i++) episode(1'b1, 3'b001, D + 1, 7, 1'b0, "");
    end_check("saturation");
    check("saturation_255", int'(coin_count), 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
